hog_svm_classifier: RTL

Linear-SVM classifier stage directly downstream of the HOG feature extractor. Consumes the HOG feature stream (`fea`/`o_valid`), multiplies each feature by a signed weight fetched from an external synchronous weight ROM, accumulates the dot product over one detection window, adds a bias and emits a signed score plus a detect flag. Fully pipelined, no stalls: back-to-back windows with zero idle cycles are supported.

---
 rtl/hog_svm_classifier_if.sv | 34 +++
 rtl/hog_svm_classifier.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/hog_svm_classifier_if.sv
// Bus bundle between the HOG feature stream, the weight ROM and the
// linear-SVM classifier. The classifier uses the slave modport; whatever
// feeds features, answers ROM reads and consumes scores uses master.
interface hog_svm_classifier_if #(
    parameter int FEA_I = 4,
    parameter int FEA_F = 8,
    parameter int WGT_W = 12,
    parameter int N_FEA = 3780,
    parameter int ACC_W = 40
);
    localparam int FEA_W  = FEA_I + FEA_F;
    localparam int ADDR_W = (N_FEA > 1) ? $clog2(N_FEA) : 1;

    logic              i_valid;
    logic [FEA_W-1:0]  i_fea;
    logic              i_clr;
    logic [ACC_W-1:0]  i_bias;
    logic [ADDR_W-1:0] o_raddr;
    logic              o_rd;
    logic [WGT_W-1:0]  i_wgt;
    logic [ACC_W-1:0]  o_score;
    logic              o_det;
    logic              o_valid;

    modport slave (
        input  i_valid, i_fea, i_clr, i_bias, i_wgt,
        output o_raddr, o_rd, o_score, o_det, o_valid
    );

    modport master (
        output i_valid, i_fea, i_clr, i_bias, i_wgt,
        input  o_raddr, o_rd, o_score, o_det, o_valid
    );
endinterface

// File: rtl/hog_svm_classifier.sv
// Linear-SVM classifier stage behind the HOG feature extractor.
// Each feature is multiplied by its weight from an external 1-cycle
// synchronous ROM, the products are summed over one detection window,
// the bias is added and a signed score plus detect flag are emitted.
// Pipeline: S0 registers the feature, S1 forms the product with the ROM
// data, S2 accumulates (or produces the score on the window's last feature).
// Optional feature: define HOG_SVM_SAT_EN to saturate the accumulator and
// the final score addition instead of wrapping at ACC_W bits.
module hog_svm_classifier #(
    parameter int FEA_I = 4,
    parameter int FEA_F = 8,
    parameter int WGT_W = 12,
    parameter int N_FEA = 3780,
    parameter int ACC_W = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    hog_svm_classifier_if.slave      bus
);
    localparam int FEA_W  = FEA_I + FEA_F;
    localparam int ADDR_W = (N_FEA > 1) ? $clog2(N_FEA) : 1;
    localparam int PROD_W = FEA_W + 1 + WGT_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_FEA - 1);

    logic [ADDR_W-1:0]        idx_q, idx_d;
    logic                     s0_valid_q, s0_valid_d;
    logic                     s0_last_q, s0_last_d;
    logic [FEA_W-1:0]         s0_fea_q, s0_fea_d;
    logic                     s1_valid_q, s1_valid_d;
    logic                     s1_last_q, s1_last_d;
    logic signed [PROD_W-1:0] s1_prod_q, s1_prod_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  score_q, score_d;
    logic                     det_q, det_d;
    logic                     valid_q, valid_d;

    logic signed [PROD_W-1:0] fea_ext;
    logic signed [PROD_W-1:0] wgt_ext;
    logic signed [ACC_W-1:0]  bias_s;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  final_sum;

    assign bias_s      = bus.i_bias;
    assign bus.o_raddr = idx_q;
    assign bus.o_rd    = bus.i_valid;
    assign bus.o_score = score_q;
    assign bus.o_det   = det_q;
    assign bus.o_valid = valid_q;

`ifdef HOG_SVM_SAT_EN
    // Three addends of at most max(ACC_W, PROD_W) bits never overflow this width.
    localparam int EXT_W = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 2;

    logic signed [EXT_W-1:0] acc_sum_ext;
    logic signed [EXT_W-1:0] final_sum_ext;

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [EXT_W-1:0] v);
        logic signed [ACC_W-1:0] r;
        if (v[EXT_W-1:ACC_W-1] == {(EXT_W-ACC_W+1){v[EXT_W-1]}}) begin
            r = v[ACC_W-1:0];
        end else if (v[EXT_W-1]) begin
            r = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            r = {1'b0, {(ACC_W-1){1'b1}}};
        end
        return r;
    endfunction

    // Accumulate and score in a wider width, then clamp to the signed ACC_W range.
    always_comb begin
        acc_sum_ext   = EXT_W'(acc_q) + EXT_W'(s1_prod_q);
        final_sum_ext = acc_sum_ext + EXT_W'(bias_s);
        acc_sum       = sat_acc(acc_sum_ext);
        final_sum     = sat_acc(final_sum_ext);
    end
`else
    // Plain two's-complement accumulate and score, wrapping at ACC_W bits.
    always_comb begin
        acc_sum   = acc_q + ACC_W'(s1_prod_q);
        final_sum = acc_sum + bias_s;
    end
`endif

    // Feature index, S0 capture and S1 signed product (feature zero-extended).
    always_comb begin
        idx_d = idx_q;
        if (bus.i_clr) begin
            idx_d = '0;
        end else if (bus.i_valid) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + ADDR_W'(1);
        end

        s0_valid_d = bus.i_valid && !bus.i_clr;
        s0_last_d  = (idx_q == LAST_IDX);
        s0_fea_d   = bus.i_fea;

        fea_ext    = PROD_W'({1'b0, s0_fea_q});
        wgt_ext    = PROD_W'($signed(bus.i_wgt));
        s1_valid_d = s0_valid_q && !bus.i_clr;
        s1_last_d  = s0_last_q;
        s1_prod_d  = fea_ext * wgt_ext;
    end

    // S2: accumulate, or on the last feature publish the score and restart from zero.
    always_comb begin
        acc_d   = acc_q;
        score_d = score_q;
        det_d   = det_q;
        valid_d = 1'b0;
        if (bus.i_clr) begin
            acc_d = '0;
        end else if (s1_valid_q) begin
            if (s1_last_q) begin
                score_d = final_sum;
                det_d   = !final_sum[ACC_W-1] && (final_sum != '0);
                valid_d = 1'b1;
                acc_d   = '0;
            end else begin
                acc_d = acc_sum;
            end
        end
    end

    // Pipeline and output registers; an asynchronous reset drops any partial window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q      <= '0;
            s0_valid_q <= 1'b0;
            s0_last_q  <= 1'b0;
            s0_fea_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_prod_q  <= '0;
            acc_q      <= '0;
            score_q    <= '0;
            det_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            s0_valid_q <= s0_valid_d;
            s0_last_q  <= s0_last_d;
            s0_fea_q   <= s0_fea_d;
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_prod_q  <= s1_prod_d;
            acc_q      <= acc_d;
            score_q    <= score_d;
            det_q      <= det_d;
            valid_q    <= valid_d;
        end
    end
endmodule
